// File: rtl/dfd_tn_pkg.sv
// Shared types for the trace network interface (TNIF) sink.
package dfd_tn_pkg;

   localparam int TNIF_NUM_SRC = 2;

   typedef enum logic {
      TNIF_SRC_DST = 1'b0,
      TNIF_SRC_NTR = 1'b1
   } tnif_src_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      FLUSH   = 2'd2,
      STOPPED = 2'd3
   } sink_state_e;

endpackage

// File: rtl/dfd_tnif_sink_fifo.sv
// Per-source beat FIFO. The head is shown combinationally on rdata, and occ
// reports how many entries are held. clear empties the FIFO synchronously.
module dfd_tnif_sink_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [PW:0]      occ
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW:0]      occ_q;

   // Storage array; the data needs no reset because occupancy guards it.
   always_ff @(posedge clock) begin
      if (push && !clear) mem_q[wr_ptr_q] <= wdata;
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else if (clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + (PW+1)'(1);
            2'b01:   occ_q <= occ_q - (PW+1)'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign occ   = occ_q;

endmodule

// File: rtl/dfd_tnif_sink.sv
// TNIF receive endpoint: buffers DST/NTR trace beats in per-source FIFOs and
// drains them round-robin into per-source circular regions of trace memory.
// Optional beat/drop statistics are built when DFD_TNIF_SINK_STATS_EN is defined.
//
// Per-source state table:
//   state   | meaning
//   IDLE    | source disabled, FIFO held empty, beats discarded
//   RUN     | beats accepted and written to the region
//   FLUSH   | beats accepted, flush requested to transmitter, done when drained
//   STOPPED | region wrapped in stop-on-wrap mode; bp+flush up, beats discarded
module dfd_tnif_sink
   import dfd_tn_pkg::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16,
   parameter int FIFO_DEPTH          = 8,
   parameter int BP_WATERMARK        = 6,
   parameter int ADDR_WIDTH          = 32
) (
   input  logic                                    clock,
   input  logic                                    reset_n,
   input  logic                                    tr_vld_in,
   input  logic                                    tr_src_in,
   input  logic [DATA_WIDTH_IN_BYTES*8-1:0]        tr_data_in,
   output logic                                    tr_gnt_out,
   output logic                                    dst_bp_out,
   output logic                                    ntr_bp_out,
   output logic                                    dst_flush_out,
   output logic                                    ntr_flush_out,
   input  logic [TNIF_NUM_SRC-1:0]                 src_en_in,
   input  logic [TNIF_NUM_SRC-1:0]                 src_flush_req_in,
   input  logic [TNIF_NUM_SRC-1:0]                 stop_on_wrap_in,
   input  logic [TNIF_NUM_SRC-1:0][ADDR_WIDTH-1:0] base_addr_in,
   input  logic [TNIF_NUM_SRC-1:0][ADDR_WIDTH-1:0] limit_addr_in,
   output logic [TNIF_NUM_SRC-1:0][ADDR_WIDTH-1:0] wr_ptr_out,
   output logic [TNIF_NUM_SRC-1:0]                 wrapped_out,
   output logic [TNIF_NUM_SRC-1:0]                 flush_done_out,
   output logic                                    mem_wr_vld_out,
   output logic [ADDR_WIDTH-1:0]                   mem_wr_addr_out,
   output logic [DATA_WIDTH_IN_BYTES*8-1:0]        mem_wr_data_out,
   input  logic                                    mem_wr_rdy_in
`ifdef DFD_TNIF_SINK_STATS_EN
   ,
   input  logic                                    clear_stats_in,
   output logic [TNIF_NUM_SRC-1:0][31:0]           beat_cnt_out,
   output logic [TNIF_NUM_SRC-1:0][31:0]           drop_cnt_out
`endif
);

   localparam int DW = DATA_WIDTH_IN_BYTES * 8;
   localparam int OW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [OW-1:0]         DEPTH_C = OW'(FIFO_DEPTH);
   localparam logic [OW-1:0]         WM_C    = OW'(BP_WATERMARK);
   localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(DATA_WIDTH_IN_BYTES);

   sink_state_e state_q [TNIF_NUM_SRC];
   sink_state_e state_d [TNIF_NUM_SRC];

   logic [TNIF_NUM_SRC-1:0][ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
   logic [TNIF_NUM_SRC-1:0]                 wrapped_q, wrapped_d;
   logic [TNIF_NUM_SRC-1:0]                 bp_q;
   logic                                    gnt_q;

   logic                  mem_vld_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DW-1:0]         mem_data_q;
   logic                  mem_src_q;
   logic                  rr_q;

   logic [TNIF_NUM_SRC-1:0]         push, pop, fifo_clr, avail, accepting, drop;
   logic [TNIF_NUM_SRC-1:0]         wr_done, wrap_evt;
   logic [TNIF_NUM_SRC-1:0][OW-1:0] occ, occ_next;
   logic [TNIF_NUM_SRC-1:0][DW-1:0] fifo_rdata;
   logic                            xfer, mem_hs, can_issue, issue, pick, room;

   // One FIFO per source.
   for (genvar g = 0; g < TNIF_NUM_SRC; g++) begin : g_fifo
      dfd_tnif_sink_fifo #(
         .WIDTH (DW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clock   (clock),
         .reset_n (reset_n),
         .clear   (fifo_clr[g]),
         .push    (push[g]),
         .wdata   (tr_data_in),
         .pop     (pop[g]),
         .rdata   (fifo_rdata[g]),
         .occ     (occ[g])
      );
   end

   // Transfer/push decode, drain arbitration and next occupancy.
   always_comb begin
      xfer      = tr_vld_in & gnt_q;
      mem_hs    = mem_vld_q & mem_wr_rdy_in;
      can_issue = !mem_vld_q || mem_wr_rdy_in;
      push      = '0;
      drop      = '0;
      accepting = '0;
      fifo_clr  = '0;
      avail     = '0;
      pop       = '0;
      occ_next  = '0;
      for (int s = 0; s < TNIF_NUM_SRC; s++) begin
         accepting[s] = (state_q[s] == RUN) || (state_q[s] == FLUSH);
         push[s]      = xfer && (tr_src_in == s[0]) && accepting[s];
         drop[s]      = xfer && (tr_src_in == s[0]) && !accepting[s];
         fifo_clr[s]  = (state_q[s] == IDLE);
         avail[s]     = (occ[s] != '0) && !fifo_clr[s];
      end
      // rr_q names the source holding priority; the other one gets it next.
      pick  = avail[rr_q] ? rr_q : ~rr_q;
      issue = can_issue && (|avail);
      pop[pick] = issue;
      for (int s = 0; s < TNIF_NUM_SRC; s++) begin
         if (fifo_clr[s])                occ_next[s] = '0;
         else if (push[s] && !pop[s])    occ_next[s] = occ[s] + OW'(1);
         else if (!push[s] && pop[s])    occ_next[s] = occ[s] - OW'(1);
         else                            occ_next[s] = occ[s];
      end
      room = 1'b1;
      for (int s = 0; s < TNIF_NUM_SRC; s++) begin
         if (occ_next[s] >= DEPTH_C) room = 1'b0;
      end
   end

   // Per-source next state, write pointer and wrap flag.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wrapped_d = wrapped_q;
      ptr_inc   = '0;
      wr_done   = '0;
      wrap_evt  = '0;
      for (int s = 0; s < TNIF_NUM_SRC; s++) begin
         ptr_inc[s]  = ptr_q[s] + STEP_C;
         // A write finishing after its source was disabled leaves ptr alone.
         wr_done[s]  = mem_hs && (mem_src_q == s[0]) && src_en_in[s] && (state_q[s] != IDLE);
         wrap_evt[s] = wr_done[s] && (ptr_inc[s] >= limit_addr_in[s]);
         if (wr_done[s]) begin
            if (wrap_evt[s]) begin
               ptr_d[s]     = base_addr_in[s];
               wrapped_d[s] = 1'b1;
            end else begin
               ptr_d[s] = ptr_inc[s];
            end
         end
         if (!src_en_in[s]) begin
            state_d[s] = IDLE;
         end else begin
            case (state_q[s])
               IDLE: begin
                  state_d[s]   = RUN;
                  ptr_d[s]     = base_addr_in[s];
                  wrapped_d[s] = 1'b0;
               end
               RUN: begin
                  if (wrap_evt[s] && stop_on_wrap_in[s]) state_d[s] = STOPPED;
                  else if (src_flush_req_in[s])          state_d[s] = FLUSH;
               end
               FLUSH: begin
                  if (wrap_evt[s] && stop_on_wrap_in[s]) state_d[s] = STOPPED;
                  else if (!src_flush_req_in[s])         state_d[s] = RUN;
               end
               default: state_d[s] = STOPPED;
            endcase
         end
      end
   end

   // Source state, pointers, grant and backpressure registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < TNIF_NUM_SRC; s++) state_q[s] <= IDLE;
         ptr_q     <= '0;
         wrapped_q <= '0;
         bp_q      <= '0;
         gnt_q     <= 1'b0;
      end else begin
         for (int s = 0; s < TNIF_NUM_SRC; s++) begin
            state_q[s] <= state_d[s];
            bp_q[s]    <= (occ_next[s] >= WM_C) || (state_d[s] == STOPPED);
         end
         ptr_q     <= ptr_d;
         wrapped_q <= wrapped_d;
         gnt_q     <= room;
      end
   end

   // Single outstanding memory write; a new one may issue on the handshake cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_vld_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_src_q  <= 1'b0;
         rr_q       <= TNIF_SRC_DST;
      end else if (issue) begin
         mem_vld_q  <= 1'b1;
         mem_addr_q <= ptr_d[pick];
         mem_data_q <= fifo_rdata[pick];
         mem_src_q  <= pick;
         rr_q       <= ~pick;
      end else if (mem_hs) begin
         mem_vld_q  <= 1'b0;
      end
   end

   // Outputs derived from registered state.
   always_comb begin
      flush_done_out = '0;
      for (int s = 0; s < TNIF_NUM_SRC; s++) begin
         flush_done_out[s] = (state_q[s] == FLUSH) && (occ[s] == '0) &&
                             !(mem_vld_q && (mem_src_q == s[0]));
      end
   end

   assign tr_gnt_out      = gnt_q;
   assign dst_bp_out      = bp_q[TNIF_SRC_DST];
   assign ntr_bp_out      = bp_q[TNIF_SRC_NTR];
   assign dst_flush_out   = (state_q[TNIF_SRC_DST] == FLUSH) || (state_q[TNIF_SRC_DST] == STOPPED);
   assign ntr_flush_out   = (state_q[TNIF_SRC_NTR] == FLUSH) || (state_q[TNIF_SRC_NTR] == STOPPED);
   assign wr_ptr_out      = ptr_q;
   assign wrapped_out     = wrapped_q;
   assign mem_wr_vld_out  = mem_vld_q;
   assign mem_wr_addr_out = mem_addr_q;
   assign mem_wr_data_out = mem_data_q;

`ifdef DFD_TNIF_SINK_STATS_EN
   logic [TNIF_NUM_SRC-1:0][31:0] beat_cnt_q, drop_cnt_q;

   // Saturating per-source counters of written and discarded beats.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else if (clear_stats_in) begin
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         for (int s = 0; s < TNIF_NUM_SRC; s++) begin
            if (mem_hs && (mem_src_q == s[0]) && (beat_cnt_q[s] != '1))
               beat_cnt_q[s] <= beat_cnt_q[s] + 32'd1;
            if (drop[s] && (drop_cnt_q[s] != '1))
               drop_cnt_q[s] <= drop_cnt_q[s] + 32'd1;
         end
      end
   end

   assign beat_cnt_out = beat_cnt_q;
   assign drop_cnt_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dfd_tnif_sink.sv
// Self-checking bench for dfd_tnif_sink (default build, statistics disabled).
`timescale 1ns/1ps
module tb_dfd_tnif_sink;

   localparam int DW = 128;
   localparam int AW = 32;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               tr_vld_in, tr_src_in, tr_gnt_out;
   logic [DW-1:0]      tr_data_in;
   logic               dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out;
   logic [1:0]         src_en_in, src_flush_req_in, stop_on_wrap_in;
   logic [1:0][AW-1:0] base_addr_in, limit_addr_in, wr_ptr_out;
   logic [1:0]         wrapped_out, flush_done_out;
   logic               mem_wr_vld_out, mem_wr_rdy_in;
   logic [AW-1:0]      mem_wr_addr_out;
   logic [DW-1:0]      mem_wr_data_out;

   dfd_tnif_sink dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .tr_vld_in        (tr_vld_in),
      .tr_src_in        (tr_src_in),
      .tr_data_in       (tr_data_in),
      .tr_gnt_out       (tr_gnt_out),
      .dst_bp_out       (dst_bp_out),
      .ntr_bp_out       (ntr_bp_out),
      .dst_flush_out    (dst_flush_out),
      .ntr_flush_out    (ntr_flush_out),
      .src_en_in        (src_en_in),
      .src_flush_req_in (src_flush_req_in),
      .stop_on_wrap_in  (stop_on_wrap_in),
      .base_addr_in     (base_addr_in),
      .limit_addr_in    (limit_addr_in),
      .wr_ptr_out       (wr_ptr_out),
      .wrapped_out      (wrapped_out),
      .flush_done_out   (flush_done_out),
      .mem_wr_vld_out   (mem_wr_vld_out),
      .mem_wr_addr_out  (mem_wr_addr_out),
      .mem_wr_data_out  (mem_wr_data_out),
      .mem_wr_rdy_in    (mem_wr_rdy_in)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          src;
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      bit            acc;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   logic src_log[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Scoreboard: every memory handshake is matched against the queue of the
   // source that owns the address region (bit 13 set => NTR region 0x2xxx).
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   always @(negedge clock) begin
      exp_t e;
      logic s;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_vld",  128'(mem_wr_vld_out), 128'(1));
            check("hold_addr", 128'(mem_wr_addr_out), 128'(prev_addr));
            check("hold_data", mem_wr_data_out, prev_data);
         end
         if (mem_wr_vld_out && mem_wr_rdy_in) begin
            s = mem_wr_addr_out[13];
            if ((s ? sb1.size() : sb0.size()) == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0h expected no write", mem_wr_addr_out);
            end else begin
               e = s ? sb1.pop_front() : sb0.pop_front();
               check("wr_addr", 128'(mem_wr_addr_out), 128'(e.addr));
               check("wr_data", mem_wr_data_out, e.data);
               src_log.push_back(s);
            end
         end
         prev_stall = mem_wr_vld_out && !mem_wr_rdy_in;
         prev_addr  = mem_wr_addr_out;
         prev_data  = mem_wr_data_out;
      end
   end

   // Present one beat, wait (bounded) for grant, record it if it should be kept.
   task automatic send_beat(input logic s, input logic [DW-1:0] d, input logic [AW-1:0] a, input bit acc);
      int n = 0;
      tr_vld_in  = 1'b1;
      tr_src_in  = s;
      tr_data_in = d;
      do begin
         @(negedge clock);
         n++;
      end while (!tr_gnt_out && n < 200);
      if (!tr_gnt_out) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout: got gnt 0 expected 1 within 200 cycles");
      end else if (acc) begin
         if (s) sb1.push_back('{addr: a, data: d});
         else   sb0.push_back('{addr: a, data: d});
      end
      @(posedge clock);
      #1;
      tr_vld_in = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((sb0.size() != 0 || sb1.size() != 0 || mem_wr_vld_out) && n < 500) begin
         @(negedge clock);
         n++;
      end
      n_checks++;
      if (n >= 500) begin
         n_fail++;
         $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, sb0.size() + sb1.size());
      end
      tick(1);
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      tr_vld_in        = 1'b0;
      tr_src_in        = 1'b0;
      tr_data_in       = '0;
      src_en_in        = '0;
      src_flush_req_in = '0;
      stop_on_wrap_in  = '0;
      base_addr_in     = '0;
      limit_addr_in    = '0;
      mem_wr_rdy_in    = 1'b1;
      sb0.delete();
      sb1.delete();
      src_log.delete();
      tick(3);
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic cfg(input int s, input logic [AW-1:0] base, input logic [AW-1:0] limit, input logic stop);
      base_addr_in[s]    = base;
      limit_addr_in[s]   = limit;
      stop_on_wrap_in[s] = stop;
      src_en_in[s]       = 1'b1;
      tick(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   vec_t vecs[9];
   logic exp_src[6];

   initial begin
      exp_src = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      // Basic transfer (DST) followed by non-stop wrap (NTR, 4-beat region).
      for (int i = 0; i < 4; i++)
         vecs[i] = '{src: 1'b0, data: {4{32'hD000_0000 + 32'(i)}},
                     addr: 32'h1000 + 32'(16 * i), acc: 1'b1};
      for (int i = 0; i < 5; i++)
         vecs[4 + i] = '{src: 1'b1, data: {4{32'hE000_0000 + 32'(i)}},
                         addr: 32'h2000 + 32'(16 * (i % 4)), acc: 1'b1};

      // Reset state
      reset_n          = 1'b0;
      tr_vld_in        = 1'b0;
      tr_src_in        = 1'b0;
      tr_data_in       = '0;
      src_en_in        = '0;
      src_flush_req_in = '0;
      stop_on_wrap_in  = '0;
      base_addr_in     = '0;
      limit_addr_in    = '0;
      mem_wr_rdy_in    = 1'b1;
      tick(2);
      check("rst_gnt",   128'(tr_gnt_out), 128'(0));
      check("rst_bp",    128'({dst_bp_out, ntr_bp_out}), 128'(0));
      check("rst_flush", 128'({dst_flush_out, ntr_flush_out}), 128'(0));
      check("rst_vld",   128'(mem_wr_vld_out), 128'(0));
      check("rst_ptr",   128'(wr_ptr_out), 128'(0));
      check("rst_wrap",  128'(wrapped_out), 128'(0));
      check("rst_fdone", 128'(flush_done_out), 128'(0));
      reset_n = 1'b1;
      tick(2);
      check("gnt_after_rst", 128'(tr_gnt_out), 128'(1));

      // Table-driven transfer and wrap
      cfg(0, 32'h1000, 32'h1100, 1'b0);
      cfg(1, 32'h2000, 32'h2040, 1'b0);
      for (int i = 0; i < 9; i++)
         send_beat(vecs[i].src, vecs[i].data, vecs[i].addr, vecs[i].acc);
      wait_idle("table");
      check("dst_wr_ptr",  128'(wr_ptr_out[0]), 128'(32'h1040));
      check("ntr_wr_ptr",  128'(wr_ptr_out[1]), 128'(32'h2010));
      check("wrapped",     128'(wrapped_out), 128'(2'b10));
      check("ntr_bp_run",  128'(ntr_bp_out), 128'(0));

      // Stop-on-wrap
      do_reset();
      cfg(1, 32'h2000, 32'h2040, 1'b1);
      for (int i = 0; i < 4; i++)
         send_beat(1'b1, {4{32'hF000_0000 + 32'(i)}}, 32'h2000 + 32'(16 * i), 1'b1);
      wait_idle("stopwrap");
      check("stop_bp",    128'(ntr_bp_out), 128'(1));
      check("stop_flush", 128'(ntr_flush_out), 128'(1));
      check("stop_wrap",  128'(wrapped_out[1]), 128'(1));
      check("stop_ptr",   128'(wr_ptr_out[1]), 128'(32'h2000));
      send_beat(1'b1, {4{32'hBAD0_0000}}, 32'h0, 1'b0);
      tick(10);
      check("stop_drop_ptr", 128'(wr_ptr_out[1]), 128'(32'h2000));
      check("stop_dst_bp",   128'(dst_bp_out), 128'(0));

      // Backpressure and grant with memory stalled
      do_reset();
      cfg(0, 32'h1000, 32'h1100, 1'b0);
      mem_wr_rdy_in = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_beat(1'b0, {4{32'hB000_0000 + 32'(i)}}, 32'h1000 + 32'(16 * i), 1'b1);
         if (i == 5) check("bp_occ5", 128'(dst_bp_out), 128'(0));
         if (i == 6) check("bp_occ6", 128'(dst_bp_out), 128'(1));
         if (i == 7) check("gnt_occ7", 128'(tr_gnt_out), 128'(1));
      end
      check("gnt_full", 128'(tr_gnt_out), 128'(0));
      tick(3);
      check("gnt_full_hold", 128'(tr_gnt_out), 128'(0));
      mem_wr_rdy_in = 1'b1;
      send_beat(1'b0, {4{32'hB000_0009}}, 32'h1090, 1'b1);
      wait_idle("bp");
      check("bp_ptr",     128'(wr_ptr_out[0]), 128'(32'h10A0));
      check("bp_release", 128'(dst_bp_out), 128'(0));

      // Round-robin arbitration
      do_reset();
      cfg(0, 32'h1000, 32'h1100, 1'b0);
      cfg(1, 32'h2000, 32'h2100, 1'b0);
      mem_wr_rdy_in = 1'b0;
      for (int i = 0; i < 3; i++)
         send_beat(1'b0, {4{32'hA000_0000 + 32'(i)}}, 32'h1000 + 32'(16 * i), 1'b1);
      for (int i = 0; i < 3; i++)
         send_beat(1'b1, {4{32'hA100_0000 + 32'(i)}}, 32'h2000 + 32'(16 * i), 1'b1);
      tick(2);
      mem_wr_rdy_in = 1'b1;
      wait_idle("arb");
      check("arb_count", 128'(src_log.size()), 128'(6));
      for (int i = 0; i < 6 && i < src_log.size(); i++)
         check($sformatf("arb_order%0d", i), 128'(src_log[i]), 128'(exp_src[i]));

      // Flush
      do_reset();
      cfg(0, 32'h1000, 32'h1100, 1'b0);
      mem_wr_rdy_in = 1'b0;
      send_beat(1'b0, {4{32'hC000_0000}}, 32'h1000, 1'b1);
      send_beat(1'b0, {4{32'hC000_0001}}, 32'h1010, 1'b1);
      src_flush_req_in[0] = 1'b1;
      tick(2);
      check("flush_out",      128'(dst_flush_out), 128'(1));
      check("flush_not_done", 128'(flush_done_out[0]), 128'(0));
      mem_wr_rdy_in = 1'b1;
      wait_idle("flush");
      check("flush_done", 128'(flush_done_out[0]), 128'(1));
      src_flush_req_in[0] = 1'b0;
      tick(2);
      check("flush_done_clr", 128'(flush_done_out[0]), 128'(0));
      check("flush_out_clr",  128'(dst_flush_out), 128'(0));

      // Reset mid-write
      do_reset();
      cfg(0, 32'h1000, 32'h1100, 1'b0);
      mem_wr_rdy_in = 1'b0;
      send_beat(1'b0, {4{32'h5555_0000}}, 32'h1000, 1'b1);
      tick(2);
      check("mid_vld_before", 128'(mem_wr_vld_out), 128'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_vld",   128'(mem_wr_vld_out), 128'(0));
      check("mid_gnt",   128'(tr_gnt_out), 128'(0));
      check("mid_ptr",   128'(wr_ptr_out), 128'(0));
      check("mid_flags", 128'({dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out, wrapped_out, flush_done_out}), 128'(0));
      sb0.delete();
      sb1.delete();
      tick(1);
      reset_n = 1'b1;
      mem_wr_rdy_in = 1'b1;
      tick(2);
      check("mid_gnt_after", 128'(tr_gnt_out), 128'(1));
      check("mid_no_write",  128'(mem_wr_vld_out), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
